// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: merges NUM_PORTS read/write/resp requesters onto one
// shared downstream memory port. One transaction is in flight at a time:
// IDLE arbitrates and latches the winner, BUSY waits for the downstream
// completion, RESP returns a one-cycle pulse to the winning requester.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int NUM_PORTS  = 2,
    parameter int ARB_MODE   = 0
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_PORTS-1:0]                  up_read,
    input  logic [NUM_PORTS-1:0]                  up_write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]       up_address,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]       up_wdata,
    input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0]   up_byte_enable,
    output logic [DATA_WIDTH-1:0]                 up_rdata,
    output logic [NUM_PORTS-1:0]                  up_resp,
    output logic                                  dn_read,
    output logic                                  dn_write,
    output logic [ADDR_WIDTH-1:0]                 dn_address,
    output logic [DATA_WIDTH-1:0]                 dn_wdata,
    output logic [DATA_WIDTH/8-1:0]               dn_byte_enable,
    input  logic [DATA_WIDTH-1:0]                 dn_rdata,
    input  logic                                  dn_resp,
    output logic                                  busy,
    output logic [$clog2(NUM_PORTS)-1:0]          grant_id
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int ID_WIDTH = $clog2(NUM_PORTS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [ID_WIDTH-1:0]   last_grant;
    logic [NUM_PORTS-1:0]  req;
    logic                  any_req;
    logic [ID_WIDTH-1:0]   winner;

    // A port requests with read, write or both; both together is a write.
    assign req     = up_read | up_write;
    assign any_req = |req;

    // Winner selection: lowest index in fixed priority, otherwise the first
    // requester found searching upward from last_grant+1 with wrap-around.
    always_comb begin
        int idx;
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        winner = '0;
        idx    = 0;
        if (ARB_MODE == 1) begin
            for (int i = NUM_PORTS - 1; i >= 0; i--) begin
                if (req[i]) winner = ID_WIDTH'(i);
            end
        end else begin
            // Walk from farthest to nearest so the nearest requester wins.
            for (int k = NUM_PORTS; k >= 1; k--) begin
                idx = (int'(last_grant) + k) % NUM_PORTS;
                if (req[idx]) winner = ID_WIDTH'(idx);
            end
        end
    end

    // Next-state logic for the IDLE -> BUSY -> RESP -> IDLE sequence.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = BUSY;
            BUSY:    if (dn_resp) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Transaction registers: latch the winner at grant, hold them for the
    // whole transaction, and capture read data on downstream completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant     <= ID_WIDTH'(NUM_PORTS - 1);
            grant_id       <= '0;
            dn_read        <= 1'b0;
            dn_write       <= 1'b0;
            dn_address     <= '0;
            dn_wdata       <= '0;
            dn_byte_enable <= '0;
            up_rdata       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_id       <= winner;
                        last_grant     <= winner;
                        dn_write       <= up_write[winner];
                        dn_read        <= ~up_write[winner];
                        dn_address     <= up_address[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
                        dn_wdata       <= up_wdata[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
                        dn_byte_enable <= up_byte_enable[int'(winner)*BE_WIDTH +: BE_WIDTH];
                    end
                end
                BUSY: begin
                    if (dn_resp) begin
                        // Writes leave the previously returned read data intact.
                        if (dn_read) up_rdata <= dn_rdata;
                        dn_read  <= 1'b0;
                        dn_write <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Completion pulse to the owner of the finished transaction.
    always_comb begin
        up_resp = '0;
        if (state == RESP) up_resp[grant_id] = 1'b1;
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of a 2-port round-robin arbiter and
// a 4-port fixed-priority arbiter, with a hand-driven downstream slave.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Round-robin instance (defaults: 2 ports, 16-bit).
    logic [1:0]  rr_up_read, rr_up_write, rr_up_resp;
    logic [31:0] rr_up_address, rr_up_wdata;
    logic [3:0]  rr_up_byte_enable;
    logic [15:0] rr_up_rdata, rr_dn_address, rr_dn_wdata, rr_dn_rdata;
    logic [1:0]  rr_dn_byte_enable;
    logic        rr_dn_read, rr_dn_write, rr_dn_resp, rr_busy;
    logic [0:0]  rr_grant_id;

    // Fixed-priority instance (4 ports).
    logic [3:0]  fp_up_read, fp_up_write, fp_up_resp;
    logic [63:0] fp_up_address, fp_up_wdata;
    logic [7:0]  fp_up_byte_enable;
    logic [15:0] fp_up_rdata, fp_dn_address, fp_dn_wdata, fp_dn_rdata;
    logic [1:0]  fp_dn_byte_enable;
    logic        fp_dn_read, fp_dn_write, fp_dn_resp, fp_busy;
    logic [1:0]  fp_grant_id;

    mem_port_arbiter u_rr (
        .clk(clk), .rst_n(rst_n),
        .up_read(rr_up_read), .up_write(rr_up_write),
        .up_address(rr_up_address), .up_wdata(rr_up_wdata),
        .up_byte_enable(rr_up_byte_enable),
        .up_rdata(rr_up_rdata), .up_resp(rr_up_resp),
        .dn_read(rr_dn_read), .dn_write(rr_dn_write),
        .dn_address(rr_dn_address), .dn_wdata(rr_dn_wdata),
        .dn_byte_enable(rr_dn_byte_enable),
        .dn_rdata(rr_dn_rdata), .dn_resp(rr_dn_resp),
        .busy(rr_busy), .grant_id(rr_grant_id)
    );

    mem_port_arbiter #(.NUM_PORTS(4), .ARB_MODE(1)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .up_read(fp_up_read), .up_write(fp_up_write),
        .up_address(fp_up_address), .up_wdata(fp_up_wdata),
        .up_byte_enable(fp_up_byte_enable),
        .up_rdata(fp_up_rdata), .up_resp(fp_up_resp),
        .dn_read(fp_dn_read), .dn_write(fp_dn_write),
        .dn_address(fp_dn_address), .dn_wdata(fp_dn_wdata),
        .dn_byte_enable(fp_dn_byte_enable),
        .dn_rdata(fp_dn_rdata), .dn_resp(fp_dn_resp),
        .busy(fp_busy), .grant_id(fp_grant_id)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Count up_resp pulses of the round-robin instance, sampled mid-cycle.
    int rr_pulses [2];
    initial begin
        rr_pulses[0] = 0;
        rr_pulses[1] = 0;
    end
    always begin
        @(negedge clk);
        #2;
        for (int i = 0; i < 2; i++) if (rr_up_resp[i] === 1'b1) rr_pulses[i]++;
    end

    // Values seen on the downstream port when a transaction starts.
    logic        cap_read, cap_write;
    logic [15:0] cap_addr, cap_wdata;
    logic [1:0]  cap_be, cap_grant;

    // Downstream slave: wait for a request, answer after wait_cycles cycles,
    // return at the RESP cycle with the observed up_resp vector.
    task automatic serve(input bit use_fp, input int wait_cycles, input logic [15:0] rdata,
                         output int lat, output logic [3:0] resp_seen);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            seen = use_fp ? (fp_dn_read | fp_dn_write) : (rr_dn_read | rr_dn_write);
        end
        check("dn_req_seen", 32'(seen), 32'd1);
        if (use_fp) begin
            cap_read = fp_dn_read;   cap_write = fp_dn_write;
            cap_addr = fp_dn_address; cap_wdata = fp_dn_wdata;
            cap_be   = fp_dn_byte_enable; cap_grant = fp_grant_id;
        end else begin
            cap_read = rr_dn_read;   cap_write = rr_dn_write;
            cap_addr = rr_dn_address; cap_wdata = rr_dn_wdata;
            cap_be   = rr_dn_byte_enable; cap_grant = {1'b0, rr_grant_id};
        end
        repeat (wait_cycles - 1) @(negedge clk);
        if (use_fp) begin
            fp_dn_rdata = rdata; fp_dn_resp = 1'b1;
        end else begin
            rr_dn_rdata = rdata; rr_dn_resp = 1'b1;
        end
        @(negedge clk);
        rr_dn_resp = 1'b0;
        fp_dn_resp = 1'b0;
        resp_seen = use_fp ? fp_up_resp : {2'b00, rr_up_resp};
        lat = n + wait_cycles;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          p0, p1;
        logic [3:0]  resp;

        rst_n = 1'b0;
        rr_up_read = '0; rr_up_write = '0; rr_up_address = '0; rr_up_wdata = '0;
        rr_up_byte_enable = '0; rr_dn_rdata = '0; rr_dn_resp = 1'b0;
        fp_up_read = '0; fp_up_write = '0; fp_up_address = '0; fp_up_wdata = '0;
        fp_up_byte_enable = '0; fp_dn_rdata = '0; fp_dn_resp = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_busy",     32'(rr_busy),       32'd0);
        check("rst_dn_read",  32'(rr_dn_read),    32'd0);
        check("rst_dn_write", 32'(rr_dn_write),   32'd0);
        check("rst_up_resp",  32'(rr_up_resp),    32'd0);
        check("rst_grant",    32'(rr_grant_id),   32'd0);
        check("rst_rdata",    32'(rr_up_rdata),   32'd0);
        check("rst_dn_addr",  32'(rr_dn_address), 32'd0);
        check("rst_fp_busy",  32'(fp_busy),       32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single read from port 1, completion 4 cycles after dn_read rises.
        p0 = rr_pulses[0]; p1 = rr_pulses[1];
        rr_up_read = 2'b10;
        rr_up_address = {16'h1234, 16'h0000};
        serve(1'b0, 4, 16'hBEEF, lat, resp);
        check("rd_dn_read",  32'(cap_read),  32'd1);
        check("rd_dn_write", 32'(cap_write), 32'd0);
        check("rd_dn_addr",  32'(cap_addr),  32'h1234);
        check("rd_grant",    32'(cap_grant), 32'd1);
        check("rd_up_resp",  32'(resp),      32'b0010);
        check("rd_up_rdata", 32'(rr_up_rdata), 32'hBEEF);
        check("rd_dn_read_low", 32'(rr_dn_read), 32'd0);
        rr_up_read = 2'b00;
        @(negedge clk);
        check("rd_resp_one_cycle", 32'(rr_up_resp), 32'd0);
        check("rd_rdata_hold", 32'(rr_up_rdata), 32'hBEEF);
        @(negedge clk);
        check("rd_port0_never", rr_pulses[0] - p0, 32'd0);
        check("rd_port1_once",  rr_pulses[1] - p1, 32'd1);

        // Round-robin contention: both ports hold reads continuously.
        rr_up_read = 2'b11;
        rr_up_address = {16'h2222, 16'h1111};
        for (int k = 0; k < 4; k++) begin
            serve(1'b0, 1 + (k % 2), 16'h1000 + 16'(k), lat, resp);
            check("rr_grant",   32'(cap_grant), 32'(k % 2));
            check("rr_dn_addr", 32'(cap_addr),  (k % 2 == 1) ? 32'h2222 : 32'h1111);
            check("rr_up_resp", 32'(resp),      32'(1 << (k % 2)));
            check("rr_rdata",   32'(rr_up_rdata), 32'h1000 + 32'(k));
        end
        rr_up_read = 2'b00;
        repeat (2) @(negedge clk);

        // Write with byte enables from port 0; read data must not change.
        rr_up_write = 2'b01;
        rr_up_address = {16'h0000, 16'h0040};
        rr_up_wdata = {16'h7777, 16'hA55A};
        rr_up_byte_enable = {2'b10, 2'b01};
        serve(1'b0, 2, 16'hDEAD, lat, resp);
        check("wr_dn_write", 32'(cap_write), 32'd1);
        check("wr_dn_read",  32'(cap_read),  32'd0);
        check("wr_dn_be",    32'(cap_be),    32'b01);
        check("wr_dn_wdata", 32'(cap_wdata), 32'hA55A);
        check("wr_dn_addr",  32'(cap_addr),  32'h0040);
        check("wr_up_resp",  32'(resp),      32'b0001);
        check("wr_rdata_kept", 32'(rr_up_rdata), 32'h1003);
        rr_up_write = 2'b00;
        repeat (2) @(negedge clk);

        // Read+write collision on port 1, fastest downstream answer.
        p0 = rr_pulses[0]; p1 = rr_pulses[1];
        rr_up_read  = 2'b10;
        rr_up_write = 2'b10;
        rr_up_address = {16'h0099, 16'h0000};
        rr_up_wdata = {16'h1111, 16'hA55A};
        serve(1'b0, 1, 16'hFACE, lat, resp);
        check("col_dn_write", 32'(cap_write), 32'd1);
        check("col_dn_read",  32'(cap_read),  32'd0);
        check("col_dn_wdata", 32'(cap_wdata), 32'h1111);
        check("col_min_latency", 32'(lat), 32'd2);
        check("col_up_resp",  32'(resp),      32'b0010);
        rr_up_read  = 2'b00;
        rr_up_write = 2'b00;
        repeat (2) @(negedge clk);
        check("col_port1_once", rr_pulses[1] - p1, 32'd1);
        check("col_port0_none", rr_pulses[0] - p0, 32'd0);
        check("col_rdata_kept", 32'(rr_up_rdata), 32'h1003);

        // Fixed priority, 4 ports: 1 and 3 request; 1 wins while it asks.
        fp_up_address = {16'h0103, 16'h0102, 16'h0101, 16'h0100};
        fp_up_read = 4'b1010;
        serve(1'b1, 1, 16'h0F0F, lat, resp);
        check("fp_grant_a",  32'(cap_grant), 32'd1);
        check("fp_addr_a",   32'(cap_addr),  32'h0101);
        check("fp_resp_a",   32'(resp),      32'b0010);
        check("fp_rdata_a",  32'(fp_up_rdata), 32'h0F0F);
        serve(1'b1, 1, 16'h0E0E, lat, resp);
        check("fp_grant_b",  32'(cap_grant), 32'd1);
        fp_up_read = 4'b1000;
        serve(1'b1, 1, 16'h0D0D, lat, resp);
        check("fp_grant_c",  32'(cap_grant), 32'd3);
        check("fp_addr_c",   32'(cap_addr),  32'h0103);
        check("fp_resp_c",   32'(resp),      32'b1000);
        fp_up_read = 4'b0000;
        repeat (2) @(negedge clk);

        // Reset in the middle of a port-0 read.
        rr_up_read = 2'b01;
        rr_up_address = {16'h0000, 16'h0777};
        @(negedge clk);
        check("rst_pre_dn_read", 32'(rr_dn_read), 32'd1);
        p0 = rr_pulses[0]; p1 = rr_pulses[1];
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_dn_read", 32'(rr_dn_read),    32'd0);
        check("rst_mid_busy",    32'(rr_busy),       32'd0);
        check("rst_mid_up_resp", 32'(rr_up_resp),    32'd0);
        check("rst_mid_dn_addr", 32'(rr_dn_address), 32'd0);
        rr_up_read = 2'b11;
        @(negedge clk);
        rst_n = 1'b1;
        serve(1'b0, 1, 16'h5555, lat, resp);
        check("rst_first_grant", 32'(cap_grant), 32'd0);
        check("rst_first_resp",  32'(resp),      32'b0001);
        rr_up_read = 2'b00;
        repeat (2) @(negedge clk);
        check("rst_port0_once", rr_pulses[0] - p0, 32'd1);
        check("rst_port1_none", rr_pulses[1] - p1, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
